led_disp_sched: RTL

- Time-shares the 6-digit seven-segment display between two requesters (A, B), e.g. the baud-rate and parity reporters.
- A granted requester's 6-digit frame is latched and held for a fixed interval, optionally blinking; then the display is released.
- Outputs drive the six 6-bit digit inputs of the display multiplexer directly. Digit format is {dp, char[4:0]}, dp active high, char 5'd29 = blank.

---
 rtl/led_disp_pkg.sv | 19 +
 rtl/led_tick_gen.sv | 26 ++
 rtl/led_disp_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_disp_pkg.sv
// Shared constants, state type and counter-width helper for the display scheduler.
package led_disp_pkg;

  localparam int DIGIT_W    = 6;
  localparam int NUM_DIGITS = 6;
  localparam int FRAME_W    = DIGIT_W * NUM_DIGITS;

  localparam logic [4:0]         CH_OFF      = 5'd29;
  localparam logic [DIGIT_W-1:0] BLANK_DIGIT = {1'b0, CH_OFF};
  localparam logic [FRAME_W-1:0] BLANK_FRAME = {NUM_DIGITS{BLANK_DIGIT}};

  typedef enum logic {IDLE, SHOW} state_t;

  // Counter width for a modulus of n; never below one bit so n = 1 stays legal.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every TICK_CNT clocks; i_clr restarts the count.
import led_disp_pkg::*;

module led_tick_gen #(
  parameter int TICK_CNT = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int           W    = cnt_w(TICK_CNT);
  localparam logic [W-1:0] LAST = W'(TICK_CNT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr)      r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/led_disp_sched.sv
// Round-robin time-sharing of the six-digit display between two requesters, with hold timer and blink.
import led_disp_pkg::*;

module led_disp_sched #(
  parameter int TICK_CNT    = 5_000_000,
  parameter int HOLD_TICKS  = 20,
  parameter int BLINK_TICKS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic [FRAME_W-1:0] frame_a,
  input  logic               blink_a,
  input  logic               req_b,
  input  logic [FRAME_W-1:0] frame_b,
  input  logic               blink_b,
  output logic               ack_a,
  output logic               ack_b,
  output logic               done,
  output logic               busy,
  output logic               owner,
  output logic [DIGIT_W-1:0] d0,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d3,
  output logic [DIGIT_W-1:0] d4,
  output logic [DIGIT_W-1:0] d5
);

  localparam int            TW         = cnt_w(HOLD_TICKS + 1);
  localparam int            BW         = cnt_w(BLINK_TICKS);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_t             r_state, w_state_nxt;
  logic               r_ptr, w_ptr_nxt;       // last served: 0 = A, 1 = B
  logic               r_owner, w_owner_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic               r_blink, w_blink_nxt;
  logic [TW-1:0]      r_tcnt, w_tcnt_nxt;
  logic [BW-1:0]      r_bcnt, w_bcnt_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_ack_a, w_ack_a_nxt;
  logic               r_ack_b, w_ack_b_nxt;
  logic               r_done, w_done_nxt;
  logic [FRAME_W-1:0] r_dig, w_dig_nxt;
  logic               w_clr;
  logic               w_pick_b;
  logic               w_tick;

  led_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_frame_nxt = r_frame;
    w_blink_nxt = r_blink;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
    w_ack_a_nxt = 1'b0;
    w_ack_b_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_clr       = 1'b0;
    w_pick_b    = 1'b0;

    case (r_state)
      IDLE: begin
        if (req_a || req_b) begin
          w_pick_b    = req_b && (!req_a || !r_ptr);
          w_state_nxt = SHOW;
          w_ptr_nxt   = w_pick_b;
          w_owner_nxt = w_pick_b;
          w_ack_a_nxt = !w_pick_b;
          w_ack_b_nxt = w_pick_b;
          w_frame_nxt = w_pick_b ? frame_b : frame_a;
          w_blink_nxt = w_pick_b ? blink_b : blink_a;
          w_tcnt_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_phase_nxt = 1'b1;
          w_clr       = 1'b1;
        end
      end
      SHOW: begin
        if (w_tick) begin
          if (r_tcnt == HOLD_LAST) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_tcnt_nxt  = '0;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
          if (r_bcnt == BLINK_LAST) begin
            w_bcnt_nxt  = '0;
            w_phase_nxt = !r_phase;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Digits are registered from next-state values so they change on the same edge as busy.
    w_dig_nxt = ((w_state_nxt == SHOW) && (!w_blink_nxt || w_phase_nxt)) ? w_frame_nxt : BLANK_FRAME;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
      r_owner <= 1'b0;
      r_frame <= BLANK_FRAME;
      r_blink <= 1'b0;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_done  <= 1'b0;
      r_dig   <= BLANK_FRAME;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_frame <= w_frame_nxt;
      r_blink <= w_blink_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_phase <= w_phase_nxt;
      r_ack_a <= w_ack_a_nxt;
      r_ack_b <= w_ack_b_nxt;
      r_done  <= w_done_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  assign ack_a = r_ack_a;
  assign ack_b = r_ack_b;
  assign done  = r_done;
  assign busy  = (r_state == SHOW);
  assign owner = r_owner;
  assign d0    = r_dig[0*DIGIT_W +: DIGIT_W];
  assign d1    = r_dig[1*DIGIT_W +: DIGIT_W];
  assign d2    = r_dig[2*DIGIT_W +: DIGIT_W];
  assign d3    = r_dig[3*DIGIT_W +: DIGIT_W];
  assign d4    = r_dig[4*DIGIT_W +: DIGIT_W];
  assign d5    = r_dig[5*DIGIT_W +: DIGIT_W];

endmodule
